pll_phase_step_ctrl: RTL and testbench

//  Sequencer that owns a PolarFire CCC/PLL's dynamic phase-rotation and powerdown pins.

---
 rtl/pll_phase_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_phase_step_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pll_phase_step_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_phase_pkg.sv
// Shared FSM encoding and default timing constants for the CCC/PLL phase-step sequencer.
package pll_phase_pkg;

  localparam int PULSE_CYC_DEF = 4;
  localparam int PD_CYC_DEF    = 16;

  typedef enum logic [2:0] {
    PD,
    WAIT_LOCK,
    IDLE,
    SETUP,
    ROT_HI,
    ROT_LO,
    LOAD,
    DONE
  } state_t;

  // States in which the PLL is expected to be locked.
  function automatic logic is_run(input state_t s);
    return (s != PD) && (s != WAIT_LOCK);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Latency: 2 CLK cycles.
// Backpressure: none, free-running.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_phase_step_ctrl.sv
// PolarFire CCC/PLL sequencer: power-up, lock qualification, relock and multi-step phase moves.
// Latency: DONE_PULSE (2*N+2)*PULSE_CYC+1 cycles after accept; 1 cycle for empty moves.
// Backpressure: REQ_READY only while idle and locked; lock loss aborts the move without DONE.
module pll_phase_step_ctrl
  import pll_phase_pkg::*;
#(
  parameter int NUM_OUT   = 4,
  parameter int STEP_W    = 8,
  parameter int POS_W     = 6,
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int PD_CYC    = PD_CYC_DEF,
  parameter int LOCK_TO_W = 16
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic [NUM_OUT-1:0]       REQ_MASK,
  input  logic                     REQ_DIR,
  input  logic [STEP_W-1:0]        REQ_STEPS,
  output logic                     DONE_PULSE,
  input  logic                     RELOCK_REQ,
  input  logic                     PLL_LOCK,
  output logic                     LOCKED,
  output logic                     LOCK_LOST,
  output logic                     PLL_POWERDOWN_N,
  output logic [NUM_OUT-1:0]       PHASE_OUT_SEL,
  output logic                     PHASE_DIRECTION,
  output logic                     PHASE_ROTATE,
  output logic                     LOAD_PHASE_N,
  output logic [NUM_OUT*POS_W-1:0] PHASE_POS
);

  localparam int TMR_MAX = (PULSE_CYC > PD_CYC) ? PULSE_CYC : PD_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] PD_LAST    = TMR_W'(PD_CYC - 1);

  state_t state, next_state;

  logic                          lock_s;
  logic [TMR_W-1:0]              tmr;
  logic [LOCK_TO_W-1:0]          to_cnt;
  logic [NUM_OUT-1:0]            mask_q;
  logic                          dir_q;
  logic [STEP_W-1:0]             remaining;
  logic [NUM_OUT-1:0][POS_W-1:0] pos_q;

  logic lock_lost_evt;
  logic accept;
  logic empty_move;
  logic pulse_last;

  logic [NUM_OUT-1:0] sel_d;
  logic               dir_d;
  logic               rot_d;
  logic               load_n_d;
  logic               done_d;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (CLK),
    .rst_n (RESETN),
    .d     (PLL_LOCK),
    .q     (lock_s)
  );

  assign lock_lost_evt = is_run(state) && !lock_s;
  assign accept        = (state == IDLE) && REQ_VALID && REQ_READY && !RELOCK_REQ && lock_s;
  assign empty_move    = (REQ_STEPS == '0) || (REQ_MASK == '0);
  assign pulse_last    = (tmr == PULSE_LAST);
  assign PHASE_POS     = pos_q;

  always_comb begin
    next_state = state;
    unique case (state)
      PD: begin
        if (tmr == PD_LAST && !RELOCK_REQ) next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (RELOCK_REQ)   next_state = PD;
        else if (lock_s)  next_state = IDLE;
        else if (&to_cnt) next_state = PD;
      end
      IDLE: begin
        if (RELOCK_REQ)  next_state = PD;
        else if (accept) next_state = empty_move ? DONE : SETUP;
      end
      SETUP:  if (pulse_last) next_state = ROT_HI;
      ROT_HI: if (pulse_last) next_state = ROT_LO;
      ROT_LO: begin
        // remaining is at least 1 here; the last low phase leads into LOAD
        if (pulse_last) next_state = (remaining == STEP_W'(1)) ? LOAD : ROT_HI;
      end
      LOAD:   if (pulse_last) next_state = DONE;
      DONE:   next_state = IDLE;
      default: next_state = PD;
    endcase
    if (lock_lost_evt) next_state = PD;
  end

  // Pins follow the current state one cycle later; a lock-loss event forces them safe at once.
  always_comb begin
    sel_d    = '0;
    dir_d    = 1'b0;
    rot_d    = 1'b0;
    load_n_d = 1'b1;
    done_d   = 1'b0;
    if (!lock_lost_evt) begin
      if (state == SETUP || state == ROT_HI || state == ROT_LO || state == LOAD) begin
        sel_d = mask_q;
        dir_d = dir_q;
      end
      rot_d    = (state == ROT_HI);
      load_n_d = (state != LOAD);
      done_d   = (state == DONE);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state           <= PD;
      tmr             <= '0;
      to_cnt          <= '0;
      mask_q          <= '0;
      dir_q           <= 1'b0;
      remaining       <= '0;
      pos_q           <= '0;
      REQ_READY       <= 1'b0;
      DONE_PULSE      <= 1'b0;
      LOCKED          <= 1'b0;
      LOCK_LOST       <= 1'b0;
      PLL_POWERDOWN_N <= 1'b0;
      PHASE_OUT_SEL   <= '0;
      PHASE_DIRECTION <= 1'b0;
      PHASE_ROTATE    <= 1'b0;
      LOAD_PHASE_N    <= 1'b1;
    end else begin
      state <= next_state;

      if (next_state != state || (state == PD && RELOCK_REQ)) tmr <= '0;
      else                                                    tmr <= tmr + 1'b1;

      if (state == WAIT_LOCK && next_state == WAIT_LOCK) to_cnt <= to_cnt + 1'b1;
      else                                                to_cnt <= '0;

      if (accept) begin
        mask_q    <= REQ_MASK;
        dir_q     <= REQ_DIR;
        remaining <= REQ_STEPS;
      end else if (state == ROT_LO && pulse_last && !lock_lost_evt) begin
        remaining <= remaining - 1'b1;
      end

      // Position moves on the edge that raises PHASE_ROTATE.
      if (next_state == PD) begin
        pos_q <= '0;
      end else if (state == ROT_HI && tmr == '0) begin
        for (int i = 0; i < NUM_OUT; i++) begin
          if (mask_q[i]) pos_q[i] <= dir_q ? pos_q[i] + 1'b1 : pos_q[i] - 1'b1;
        end
      end

      REQ_READY       <= (next_state == IDLE);
      LOCKED          <= is_run(next_state);
      PLL_POWERDOWN_N <= (next_state != PD);

      if (lock_lost_evt)   LOCK_LOST <= 1'b1;
      else if (RELOCK_REQ) LOCK_LOST <= 1'b0;

      PHASE_OUT_SEL   <= sel_d;
      PHASE_DIRECTION <= dir_d;
      PHASE_ROTATE    <= rot_d;
      LOAD_PHASE_N    <= load_n_d;
      DONE_PULSE      <= done_d;
    end
  end

endmodule

// File: tb/tb_pll_phase_step_ctrl.sv
// Self-checking bench for pll_phase_step_ctrl: vector table of moves with a scoreboard,
// plus hand-written power-up, lock-loss, timeout and relock sequences.
module tb_pll_phase_step_ctrl;

  localparam int P = 4;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [3:0]  REQ_MASK;
  logic        REQ_DIR;
  logic [7:0]  REQ_STEPS;
  logic        DONE_PULSE;
  logic        RELOCK_REQ;
  logic        PLL_LOCK;
  logic        LOCKED;
  logic        LOCK_LOST;
  logic        PLL_POWERDOWN_N;
  logic [3:0]  PHASE_OUT_SEL;
  logic        PHASE_DIRECTION;
  logic        PHASE_ROTATE;
  logic        LOAD_PHASE_N;
  logic [23:0] PHASE_POS;

  always #5 CLK = ~CLK;

  pll_phase_step_ctrl #(
    .NUM_OUT(4), .STEP_W(8), .POS_W(6), .PULSE_CYC(P), .PD_CYC(16), .LOCK_TO_W(6)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_MASK(REQ_MASK), .REQ_DIR(REQ_DIR), .REQ_STEPS(REQ_STEPS), .DONE_PULSE(DONE_PULSE),
    .RELOCK_REQ(RELOCK_REQ), .PLL_LOCK(PLL_LOCK), .LOCKED(LOCKED), .LOCK_LOST(LOCK_LOST),
    .PLL_POWERDOWN_N(PLL_POWERDOWN_N), .PHASE_OUT_SEL(PHASE_OUT_SEL),
    .PHASE_DIRECTION(PHASE_DIRECTION), .PHASE_ROTATE(PHASE_ROTATE),
    .LOAD_PHASE_N(LOAD_PHASE_N), .PHASE_POS(PHASE_POS)
  );

  int n_chk = 0;
  int n_err = 0;

  // Pin activity monitor, sampled on the falling edge.
  logic [3:0] cur_mask = '0;
  logic       cur_dir  = 1'b0;
  logic       rot_prev = 1'b0;
  int rot_rises = 0;
  int rot_hi    = 0;
  int load_lo   = 0;
  int sel_bad   = 0;
  int done_cnt  = 0;

  always @(negedge CLK) begin
    rot_prev <= PHASE_ROTATE;
    if (PHASE_ROTATE && !rot_prev) rot_rises <= rot_rises + 1;
    if (PHASE_ROTATE) rot_hi <= rot_hi + 1;
    if (!LOAD_PHASE_N) load_lo <= load_lo + 1;
    if ((PHASE_ROTATE || !LOAD_PHASE_N) && (PHASE_OUT_SEL != cur_mask || PHASE_DIRECTION != cur_dir))
      sel_bad <= sel_bad + 1;
    if (DONE_PULSE) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    int          lat;
    logic [23:0] pos;
    int          rises;
    int          hi;
    int          load;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0]  mask;
    logic        dir;
    logic [7:0]  steps;
    logic        relock_mid;
    logic [23:0] pos;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [23:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!REQ_READY && n < 400) begin
      step();
      n++;
    end
    check(nm, REQ_READY, 1);
  endtask

  task automatic do_move(input logic [3:0] m, input logic d, input logic [7:0] s,
                         input logic rl, input logic [23:0] ep);
    exp_t e;
    exp_t got;
    int   lat;
    int   r0, h0, l0, b0;
    bit   act;
    wait_ready("ready_before_move");
    act     = (m != 4'd0) && (s != 8'd0);
    e.lat   = act ? (2 * int'(s) + 2) * P + 1 : 1;
    e.pos   = ep;
    e.rises = act ? int'(s) : 0;
    e.hi    = act ? int'(s) * P : 0;
    e.load  = act ? P : 0;
    cur_mask = m;
    cur_dir  = d;
    r0 = rot_rises; h0 = rot_hi; l0 = load_lo; b0 = sel_bad;
    REQ_MASK  = m;
    REQ_DIR   = d;
    REQ_STEPS = s;
    REQ_VALID = 1'b1;
    step();
    REQ_VALID = 1'b0;
    sb.push_back(e);
    check("ready_low_after_accept", REQ_READY, 0);
    lat = 0;
    while (!DONE_PULSE && lat < 3000) begin
      step();
      lat++;
      RELOCK_REQ = rl && (lat == 3);
    end
    RELOCK_REQ = 1'b0;
    check("done_seen", DONE_PULSE, 1);
    got = sb.pop_front();
    check("done_latency", lat, got.lat);
    check("ready_at_done", REQ_READY, 1);
    check("sel_cleared_at_done", PHASE_OUT_SEL, 0);
    check("phase_pos", PHASE_POS, got.pos);
    #5;  // let the monitor take its falling-edge sample of the DONE cycle
    check("rotate_pulses", rot_rises - r0, got.rises);
    check("rotate_high_cycles", rot_hi - h0, got.hi);
    check("load_low_cycles", load_lo - l0, got.load);
    check("sel_dir_stable", sel_bad - b0, 0);
    step();
    check("done_one_cycle", DONE_PULSE, 0);
  endtask

  initial begin
    int n;
    int rs;
    int d0;
    int r0;
    logic prev;

    tbl[0] = '{4'b0101, 1'b1, 8'd3, 1'b0, pk(3, 0, 3, 0)};
    tbl[1] = '{4'b0010, 1'b0, 8'd2, 1'b0, pk(3, 62, 3, 0)};
    tbl[2] = '{4'b0010, 1'b1, 8'd0, 1'b0, pk(3, 62, 3, 0)};
    tbl[3] = '{4'b0000, 1'b1, 8'd5, 1'b0, pk(3, 62, 3, 0)};
    tbl[4] = '{4'b1111, 1'b1, 8'd1, 1'b1, pk(4, 63, 4, 1)};
    tbl[5] = '{4'b1000, 1'b0, 8'd2, 1'b0, pk(4, 63, 4, 63)};
    tbl[6] = '{4'b0010, 1'b1, 8'd1, 1'b0, pk(4, 0, 4, 63)};

    RESETN = 1'b0; PLL_LOCK = 1'b0; REQ_VALID = 1'b0; REQ_MASK = '0;
    REQ_DIR = 1'b0; REQ_STEPS = '0; RELOCK_REQ = 1'b0;
    repeat (3) step();
    check("rst_ready", REQ_READY, 0);
    check("rst_done", DONE_PULSE, 0);
    check("rst_locked", LOCKED, 0);
    check("rst_lock_lost", LOCK_LOST, 0);
    check("rst_pd_n", PLL_POWERDOWN_N, 0);
    check("rst_sel", PHASE_OUT_SEL, 0);
    check("rst_dir", PHASE_DIRECTION, 0);
    check("rst_rotate", PHASE_ROTATE, 0);
    check("rst_load_n", LOAD_PHASE_N, 1);
    check("rst_pos", PHASE_POS, 0);

    // Power-up: powerdown held for 16 cycles, lock_s rises at cycle 40.
    RESETN = 1'b1;
    repeat (15) step();
    check("pd_n_low_cycle15", PLL_POWERDOWN_N, 0);
    step();
    check("pd_n_high_cycle16", PLL_POWERDOWN_N, 1);
    repeat (22) step();
    PLL_LOCK = 1'b1;
    repeat (2) step();
    check("locked_not_yet", LOCKED, 0);
    check("ready_not_yet", REQ_READY, 0);
    step();
    check("locked_after_lock_s", LOCKED, 1);
    check("ready_after_lock_s", REQ_READY, 1);

    foreach (tbl[i]) do_move(tbl[i].mask, tbl[i].dir, tbl[i].steps, tbl[i].relock_mid, tbl[i].pos);
    check("scoreboard_empty", sb.size(), 0);

    // Lock loss during the second ROT_HI.
    wait_ready("ready_before_abort_move");
    cur_mask = 4'b0001; cur_dir = 1'b1;
    d0 = done_cnt;
    REQ_MASK = 4'b0001; REQ_DIR = 1'b1; REQ_STEPS = 8'd3; REQ_VALID = 1'b1;
    step();
    REQ_VALID = 1'b0;
    rs = 0; prev = 1'b0; n = 0;
    while (rs < 2 && n < 200) begin
      step();
      n++;
      if (PHASE_ROTATE && !prev) rs++;
      prev = PHASE_ROTATE;
    end
    check("second_rotate_seen", rs, 2);
    PLL_LOCK = 1'b0;
    repeat (2) step();
    check("rotate_before_sync", PHASE_ROTATE, 1);
    step();
    check("abort_rotate", PHASE_ROTATE, 0);
    check("abort_load_n", LOAD_PHASE_N, 1);
    check("abort_sel", PHASE_OUT_SEL, 0);
    check("abort_locked", LOCKED, 0);
    check("abort_lock_lost", LOCK_LOST, 1);
    check("abort_ready", REQ_READY, 0);
    check("abort_pd_n", PLL_POWERDOWN_N, 0);
    check("abort_pos_cleared", PHASE_POS, 0);

    // Lock held low: PD 16 cycles, WAIT_LOCK 64 cycles, repeating.
    n = 0;
    while (!PLL_POWERDOWN_N && n < 300) begin step(); n++; end
    check("pd_len_1", n, 16);
    n = 0;
    while (PLL_POWERDOWN_N && n < 300) begin step(); n++; end
    check("wait_lock_timeout_len", n, 64);
    n = 0;
    while (!PLL_POWERDOWN_N && n < 300) begin step(); n++; end
    check("pd_len_2", n, 16);
    check("no_done_after_abort", done_cnt - d0, 0);
    check("lock_lost_sticky_retry", LOCK_LOST, 1);

    // Relock, then RELOCK_REQ with a simultaneous VALID in IDLE.
    PLL_LOCK = 1'b1;
    wait_ready("ready_after_relock");
    check("relocked", LOCKED, 1);
    check("lock_lost_still_set", LOCK_LOST, 1);
    d0 = done_cnt; r0 = rot_rises;
    REQ_MASK = 4'b0001; REQ_DIR = 1'b1; REQ_STEPS = 8'd1;
    REQ_VALID = 1'b1; RELOCK_REQ = 1'b1;
    step();
    REQ_VALID = 1'b0; RELOCK_REQ = 1'b0;
    check("relock_clears_lost", LOCK_LOST, 0);
    check("relock_ready", REQ_READY, 0);
    check("relock_locked", LOCKED, 0);
    check("relock_pd_n", PLL_POWERDOWN_N, 0);
    wait_ready("ready_after_relock_req");
    check("relock_no_done", done_cnt - d0, 0);
    check("relock_no_rotate", rot_rises - r0, 0);
    check("relock_pos_zero", PHASE_POS, 0);

    do_move(4'b0001, 1'b0, 8'd1, 1'b0, pk(63, 0, 0, 0));
    check("scoreboard_empty_end", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
